// File: rtl/sap_pkg.sv
// Shared types and sizes for the SAP-style CPU memory path.
package sap_pkg;

    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        WAIT_REL
    } ram_state_t;

endpackage

// File: rtl/ram_16x8_if.sv
// Signal bundle between the MAR/input-register stage and the RAM.
interface ram_16x8_if #(
    parameter int ADDR_W = sap_pkg::ADDR_W,
    parameter int DATA_W = sap_pkg::DATA_W
) ();

    logic              prog;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic              n_write;
    logic              n_enable;
    logic [DATA_W-1:0] bus_out;
    logic              bus_oe;
    logic              busy;
    logic [ADDR_W-1:0] wr_ptr;

    modport master (
        output prog, addr, data_in, n_write, n_enable,
        input  bus_out, bus_oe, busy, wr_ptr
    );

    modport slave (
        input  prog, addr, data_in, n_write, n_enable,
        output bus_out, bus_oe, busy, wr_ptr
    );

endinterface

// File: rtl/sync_fall_detect.sv
// Two-flop synchronizer for an asynchronous button pin plus a
// single-cycle falling-edge pulse; all flops reset to the released level.
module sync_fall_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pin,
    output logic o_sync,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/ram_16x8.sv
// 16x8 program/data RAM: button-driven writes in programming mode,
// registered reads every cycle. Option: RAM_AUTO_INC_EN (pointer writes).
module ram_16x8 #(
    parameter int ADDR_W = sap_pkg::ADDR_W,
    parameter int DATA_W = sap_pkg::DATA_W
) (
    input  logic       clk,
    input  logic       rst_n,
    ram_16x8_if.slave  bus
);

    import sap_pkg::*;

    localparam int DEPTH = 1 << ADDR_W;

    ram_state_t        r_state;
    ram_state_t        w_next;
    logic              w_capture;
    logic              w_commit;
    logic              w_sync;
    logic              w_fall;
    logic [DATA_W-1:0] r_hold_data;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_bus_out;
    logic              r_bus_oe;

    sync_fall_detect u_wr_btn (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_pin  (bus.n_write),
        .o_sync (w_sync),
        .o_fall (w_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // One press yields one write: WAIT_REL holds until the pin is released.
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_commit  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_fall && bus.prog) begin
                    w_capture = 1'b1;
                    w_next    = WRITE;
                end
            end
            WRITE: begin
                w_commit = 1'b1;
                w_next   = WAIT_REL;
            end
            WAIT_REL: begin
                if (w_sync) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_data <= '0;
        end else if (w_capture) begin
            r_hold_data <= bus.data_in;
        end
    end

`ifdef RAM_AUTO_INC_EN
    logic [ADDR_W-1:0] r_wr_ptr;

    // A write already in flight finishes at the old pointer even if prog drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
        end else if (w_commit && bus.prog) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
        end else if (!bus.prog) begin
            r_wr_ptr <= '0;
        end
    end

    assign w_waddr    = r_wr_ptr;
    assign bus.wr_ptr = r_wr_ptr;
`else
    logic [ADDR_W-1:0] r_hold_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_addr <= '0;
        end else if (w_capture) begin
            r_hold_addr <= bus.addr;
        end
    end

    assign w_waddr    = r_hold_addr;
    assign bus.wr_ptr = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            r_mem[w_waddr] <= r_hold_data;
        end
    end

    // Read sees the pre-write word on a same-edge collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_out <= '0;
            r_bus_oe  <= 1'b0;
        end else begin
            r_bus_out <= r_mem[bus.addr];
            r_bus_oe  <= ~bus.n_enable;
        end
    end

    assign bus.bus_out = r_bus_out;
    assign bus.bus_oe  = r_bus_oe;
    assign bus.busy    = (r_state != IDLE);

endmodule

// File: tb/tb_ram_16x8.sv
// Directed plus randomized checks of ram_16x8 against an array model.
module tb_ram_16x8;

`ifdef RAM_AUTO_INC_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    ram_16x8_if bif ();

    ram_16x8 u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] mem_m [16];
    logic [3:0] ptr_m;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] waddr(input logic [3:0] a);
        return AUTO ? ptr_m : a;
    endfunction

    task automatic model_write(input logic [3:0] a, input logic [7:0] d);
        mem_m[waddr(a)] = d;
        ptr_m = ptr_m + 4'd1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
        ptr_m = 4'd0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (bif.busy && k < 20) begin
            tick();
            k++;
        end
        chk("idle_timeout", {31'd0, bif.busy}, 32'd0);
    endtask

    task automatic press(input int len);
        logic [3:0] a;
        logic [7:0] d;
        logic       p;
        a = bif.addr;
        d = bif.data_in;
        p = bif.prog;
        bif.n_write = 1'b0;
        repeat (len) tick();
        bif.n_write = 1'b1;
        wait_idle();
        tick();
        if (p) model_write(a, d);
    endtask

    task automatic rd(input string tag, input logic [3:0] a);
        bif.addr     = a;
        bif.n_enable = 1'b0;
        tick();
        chk(tag, {24'd0, bif.bus_out}, {24'd0, mem_m[a]});
        chk({tag, "_oe"}, {31'd0, bif.bus_oe}, 32'd1);
        bif.n_enable = 1'b1;
    endtask

    initial begin
        logic       seen;
        logic [3:0] ra;

        rst_n        = 1'b0;
        bif.prog     = 1'b0;
        bif.addr     = '0;
        bif.data_in  = '0;
        bif.n_write  = 1'b1;
        bif.n_enable = 1'b1;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bus_out", {24'd0, bif.bus_out}, 32'd0);
        chk("rst_bus_oe", {31'd0, bif.bus_oe}, 32'd0);
        chk("rst_busy", {31'd0, bif.busy}, 32'd0);
        chk("rst_wr_ptr", {28'd0, bif.wr_ptr}, 32'd0);
        rst_n = 1'b1;
        tick();

        // basic write with edge-by-edge timing
        bif.prog     = 1'b1;
        bif.addr     = 4'h3;
        bif.data_in  = 8'hA5;
        bif.n_enable = 1'b0;
        bif.n_write  = 1'b0;
        tick();
        tick();
        chk("busy_e1", {31'd0, bif.busy}, 32'd0);
        tick();
        chk("busy_e2", {31'd0, bif.busy}, 32'd1);
        tick();
        chk("bus_e3_old", {24'd0, bif.bus_out}, {24'd0, mem_m[3]});
        model_write(4'h3, 8'hA5);
        tick();
        chk("bus_e4_new", {24'd0, bif.bus_out}, {24'd0, mem_m[3]});
        chk("oe_e4", {31'd0, bif.bus_oe}, 32'd1);
        bif.n_write = 1'b1;
        wait_idle();
        tick();
        bif.n_enable = 1'b1;
        tick();
        chk("oe_off", {31'd0, bif.bus_oe}, 32'd0);

        // run-mode lockout
        bif.prog    = 1'b0;
        ptr_m       = 4'd0;
        bif.data_in = 8'hFF;
        seen        = 1'b0;
        tick();
        bif.n_write = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen |= bif.busy;
        end
        bif.n_write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen |= bif.busy;
        end
        chk("lock_busy", {31'd0, seen}, 32'd0);
        rd("lock_mem3", 4'h3);

        // held-low press: one write, busy until two cycles after release
        bif.prog    = 1'b1;
        bif.addr    = 4'h7;
        bif.data_in = 8'h3C;
        tick();
        bif.n_write = 1'b0;
        repeat (10) tick();
        bif.data_in = 8'h99;
        repeat (40) tick();
        chk("hold_busy", {31'd0, bif.busy}, 32'd1);
        bif.n_write = 1'b1;
        tick();
        chk("rel_busy_r0", {31'd0, bif.busy}, 32'd1);
        tick();
        chk("rel_busy_r1", {31'd0, bif.busy}, 32'd1);
        tick();
        chk("rel_busy_r2", {31'd0, bif.busy}, 32'd0);
        model_write(4'h7, 8'h3C);
        tick();
        rd("hold_mem7", 4'h7);

        // address moves right after capture
        bif.addr    = 4'h5;
        bif.data_in = 8'h5A;
        tick();
        bif.n_write = 1'b0;
        repeat (3) tick();
        bif.addr = 4'h6;
        repeat (2) tick();
        bif.n_write = 1'b1;
        wait_idle();
        tick();
        model_write(4'h5, 8'h5A);
        rd("achg_mem5", 4'h5);
        rd("achg_mem6", 4'h6);

        // reset in the middle of a write
        bif.addr    = 4'h9;
        bif.data_in = 8'h77;
        tick();
        bif.n_write = 1'b0;
        repeat (3) tick();
        chk("mid_busy", {31'd0, bif.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, bif.busy}, 32'd0);
        chk("mid_rst_oe", {31'd0, bif.bus_oe}, 32'd0);
        chk("mid_rst_out", {24'd0, bif.bus_out}, 32'd0);
        bif.n_write = 1'b1;
        tick();
        rst_n = 1'b1;
        model_clear();
        tick();
        for (int i = 0; i < 16; i++) rd("post_rst", 4'(i));

`ifdef RAM_AUTO_INC_EN
        bif.prog = 1'b0;
        tick();
        bif.prog = 1'b1;
        ptr_m    = 4'd0;
        tick();
        for (int i = 0; i < 17; i++) begin
            bif.addr    = 4'($urandom_range(0, 15));
            bif.data_in = 8'(8'h10 + i);
            press(4);
        end
        chk("ai_ptr", {28'd0, bif.wr_ptr}, 32'd1);
        chk("ai_mem0", {24'd0, mem_m[0]}, 32'h20);
        for (int i = 0; i < 16; i++) rd("ai_mem", 4'(i));
        bif.prog = 1'b0;
        ptr_m    = 4'd0;
        tick();
        chk("ai_ptr_clr", {28'd0, bif.wr_ptr}, 32'd0);
`endif

        // randomized presses
        for (int i = 0; i < 24; i++) begin
            bif.prog    = ($urandom_range(0, 3) != 0);
            if (!bif.prog) ptr_m = 4'd0;
            bif.addr    = 4'($urandom_range(0, 15));
            bif.data_in = 8'($urandom);
            ra          = bif.addr;
            tick();
            press($urandom_range(3, 8));
            rd("rnd_same", ra);
            rd("rnd_any", 4'($urandom_range(0, 15)));
        end

`ifndef RAM_AUTO_INC_EN
        chk("ptr_tied", {28'd0, bif.wr_ptr}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
